mdu: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the E stage beside the ALU. It accepts one operation per start pulse and holds `busy` for a fixed, per-class latency, writing HI/LO on completion. It also services single-cycle HI/LO moves. The hazard unit must stall D whenever D holds an MDU-class instruction and (`start` || `busy`) is high; E's stall-bubble reset keeps `start` low for inserted bubbles.

---
 rtl/mdu.sv | 176 +++++++++++++++++
 tb/tb_mdu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// One operation is accepted per start pulse; busy holds for a fixed per-class
// latency and HI/LO are written on the completion edge. MTHI/MTLO act in one cycle.
// Optional feature macro: MDU_MAC_EN enables MADD/MADDU/MSUB/MSUBU (ops 9-12);
// when undefined those ops behave as NOP and no accumulate path exists.
module mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2     = 2 * WIDTH;
    localparam int unsigned CntMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             is_mul_op, is_div_op, is_mac_op;
    logic             signed_op;
    logic [W2-1:0]    a_ext, b_ext, prod;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic [W2-1:0]    res;
    logic             res_wr;

    // Classify the incoming op for issue.
    always_comb begin
        is_mul_op = (op == OpMult) || (op == OpMultu);
        is_div_op = (op == OpDiv) || (op == OpDivu);
`ifdef MDU_MAC_EN
        is_mac_op = (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
`else
        is_mac_op = 1'b0;
`endif
    end

    // Product and signed/unsigned quotient/remainder from the latched operands.
    always_comb begin
        signed_op = (op_q == OpMult) || (op_q == OpDiv) || (op_q == OpMadd) || (op_q == OpMsub);
        a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;

        // Magnitude divide; MIN / -1 falls out as quotient MIN, remainder 0.
        a_neg = signed_op && a_q[WIDTH-1];
        b_neg = signed_op && b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        q_mag = (b_mag != '0) ? (a_mag / b_mag) : '0;
        r_mag = (b_mag != '0) ? (a_mag % b_mag) : '0;
        quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    // Completion result selected by the latched op; divide by zero writes nothing.
    always_comb begin
        res    = {hi_q, lo_q};
        res_wr = 1'b0;
        case (op_q)
            OpMult, OpMultu: begin
                res    = prod;
                res_wr = 1'b1;
            end
            OpDiv, OpDivu: begin
                if (b_q != '0) begin
                    res    = {rem, quot};
                    res_wr = 1'b1;
                end
            end
`ifdef MDU_MAC_EN
            OpMadd, OpMaddu: begin
                res    = {hi_q, lo_q} + prod;
                res_wr = 1'b1;
            end
            OpMsub, OpMsubu: begin
                res    = {hi_q, lo_q} - prod;
                res_wr = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Next state: count down, retire at cnt == 1, otherwise accept a new op.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        if (cnt_q > CntOne) begin
            cnt_d = cnt_q - CntOne;
        end else if (cnt_q == CntOne) begin
            cnt_d = '0;
            if (res_wr) begin
                {hi_d, lo_d} = res;
            end
        end else if (start) begin
            if (is_mul_op || is_div_op || is_mac_op) begin
                a_d   = A;
                b_d   = B;
                op_d  = op;
                cnt_d = is_div_op ? DivLoad : MultLoad;
            end else if (op == OpMthi) begin
                hi_d = A;
            end else if (op == OpMtlo) begin
                lo_d = A;
            end
        end
    end

    // State register with synchronous reset; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs: busy flag, register views, and the combinational MFHI/MFLO read.
    always_comb begin
        busy = (cnt_q != '0);
        hi   = hi_q;
        lo   = lo_q;
        rd   = '0;
        if (op == OpMfhi) begin
            rd = hi_q;
        end else if (op == OpMflo) begin
            rd = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against an arithmetic reference model.
// Honours MDU_MAC_EN the same way the design does.
module tb_mdu;

`ifdef MDU_MAC_EN
    localparam bit MacEn = 1'b1;
`else
    localparam bit MacEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] rd, hi, lo;

    logic [31:0] hi_m, lo_m;
    int          errors = 0;
    int          checks = 0;

    mdu #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .A    (a),
        .B    (b),
        .busy (busy),
        .rd   (rd),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: applies one op to hi_m/lo_m and returns the expected busy length.
    function automatic int model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p, acc;
        longint      sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd1: begin p = 64'(sx * sy); {hi_m, lo_m} = p; return 5; end
            4'd2: begin p = {32'h0, x} * {32'h0, y}; {hi_m, lo_m} = p; return 5; end
            4'd3: begin
                if (y != 0) begin
                    lo_m = 32'(sx / sy);
                    hi_m = 32'(sx % sy);
                end
                return 10;
            end
            4'd4: begin
                if (y != 0) begin
                    lo_m = x / y;
                    hi_m = x % y;
                end
                return 10;
            end
            4'd5: begin hi_m = x; return 0; end
            4'd6: begin lo_m = x; return 0; end
            4'd9, 4'd10, 4'd11, 4'd12: begin
                if (!MacEn) return 0;
                if (o == 4'd9 || o == 4'd11) p = 64'(sx * sy);
                else p = {32'h0, x} * {32'h0, y};
                acc = {hi_m, lo_m};
                acc = (o >= 4'd11) ? acc - p : acc + p;
                {hi_m, lo_m} = acc;
                return 5;
            end
            default: return 0;
        endcase
    endfunction

    // Pulse start for one edge, then count busy cycles (bounded).
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_rd(input string tag);
        op = 4'd7; #1;
        check({tag, "_mfhi"}, 64'(rd), 64'(hi_m));
        op = 4'd8; #1;
        check({tag, "_mflo"}, 64'(rd), 64'(lo_m));
        op = 4'd0; #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        int lat, n;
        lat = model(o, x, y);
        issue(o, x, y, n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_hi"}, 64'(hi), 64'(hi_m));
        check({tag, "_lo"}, 64'(lo), 64'(lo_m));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'h0);
        check("rst_lo", 64'(lo), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rd", 64'(rd), 64'h0);
        rst = 1'b0;

        // Directed cases from the plan, with hard-coded expectations as well.
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi_k", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_k", 64'(lo), 64'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi_k", 64'(hi), 64'h2);
        check("multu_lo_k", 64'(lo), 64'hFFFF_FFFA);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_k", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_k", 64'(hi), 64'hFFFF_FFFF);
        run_op("divu0", 4'd4, 32'd7, 32'd0);
        check("divu0_hi_k", 64'(hi), 64'hFFFF_FFFF);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo_k", 64'(lo), 64'h8000_0000);
        check("divovf_hi_k", 64'(hi), 64'h0);
        run_op("mthi", 4'd5, 32'h1234_5678, 32'd0);
        check_rd("mthi");
        check("mfhi_k", 64'(hi), 64'h1234_5678);
        run_op("mtlo", 4'd6, 32'hCAFE_F00D, 32'd0);
        check_rd("mtlo");

        // Start while busy is ignored; busy ends 5 cycles after the first issue.
        void'(model(4'd1, 32'd5, 32'd7));
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        op = 4'd3; a = 32'd100; b = 32'd3;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (n > 1) begin start = 1'b0; op = 4'd0; end
            @(posedge clk); #1;
        end
        start = 1'b0; op = 4'd0;
        check("ovl_lat", 64'(n), 64'd5);
        check("ovl_lo", 64'(lo), 64'd35);
        check("ovl_hi", 64'(hi), 64'd0);
        hi_m = hi; lo_m = 32'd35;
        repeat (12) @(posedge clk);
        #1;
        check("ovl_late_lo", 64'(lo), 64'd35);

        // Reset during a divide discards the result.
        @(negedge clk);
        start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        check("rstmid_busy", 64'(busy), 64'h0);
        check("rstmid_hi", 64'(hi), 64'h0);
        check("rstmid_lo", 64'(lo), 64'h0);
        repeat (12) @(posedge clk);
        #1;
        check("rstmid_late_hi", 64'(hi), 64'h0);
        check("rstmid_late_lo", 64'(lo), 64'h0);

        // Reset beats a simultaneous MTHI.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; op = 4'd0;
        check("rststart_hi", 64'(hi), 64'h0);

        // Accumulate: HI:LO = 0:10, MADD 3*4.
        run_op("mac_mthi", 4'd5, 32'd0, 32'd0);
        run_op("mac_mtlo", 4'd6, 32'd10, 32'd0);
        run_op("madd", 4'd9, 32'd3, 32'd4);
        check("madd_lo_k", 64'(lo), MacEn ? 64'd22 : 64'd10);

        // Randomized ops with corner-biased operands.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y;
            int          sel;
            o   = 4'($urandom_range(0, 15));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) begin x = 32'($urandom_range(0, 40)) - 32'd20; y = 32'($urandom_range(1, 9)); end
            run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y);
            if (i % 8 == 0) check_rd($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
